// File: rtl/ex_muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// func3 opcodes, the M-extension funct7 value, FSM state encodings and width.
package ex_muldiv_seq_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Two's-complement negate when the flag is set.
  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] val);
    return neg ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_iter_dp.sv
// Iterative datapath for the multiply/divide sequencer.
// Holds a 64-bit accumulator (product, or remainder:quotient) and the latched
// magnitude of operand B. Each enabled step performs one shift-add multiply
// iteration or one restoring-divide iteration; 32 steps complete an operation.
module ex_muldiv_seq_iter_dp
  import ex_muldiv_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_top;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;

  // Next accumulator: load operands, or advance one multiply/divide iteration.
  always_comb begin
    acc_d     = acc_q;
    divisor_d = divisor_q;
    // Multiply: add B into the upper half when the lsb is set, then shift right with carry.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, divisor_q} : '0);
    // Divide: partial remainder shifted left with the next dividend bit appended.
    div_top   = acc_q[2*XLEN-1:XLEN-1];
    div_ge    = (div_top >= {1'b0, divisor_q});
    div_rem   = div_top[XLEN-1:0] - divisor_q;
    if (i_load) begin
      acc_d     = {{XLEN{1'b0}}, i_a};
      divisor_d = i_b;
    end else if (i_step) begin
      if (i_is_div) begin
        if (div_ge) begin
          acc_d = {div_rem, acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {div_top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
    end
  end

  // Accumulator and divisor registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      divisor_q <= '0;
    end else begin
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M multi-cycle MUL/DIV/REM sequencer sitting beside the EX-stage ALU.
// Accepts an op from EX, stalls the pipeline through 32 iterations plus a sign
// fixup cycle, then presents a one-cycle result beat.
// Optional build macro MULDIV_FAST_ZERO_EN: ops with a zero operand skip the
// iteration and complete after a single stall cycle with identical results.
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        func3_q, func3_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic              neg_q, neg_d;
  logic              b_zero_q, b_zero_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              res_neg, in_b_zero, in_ovf;

  logic              dp_load, dp_step;
  logic [2*XLEN-1:0] dp_acc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   sign_result;

`ifdef MULDIV_FAST_ZERO_EN
  logic              fast_zero;
  logic [XLEN-1:0]   fast_result;
`endif

  ex_muldiv_seq_iter_dp u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (dp_load),
    .i_step   (dp_step),
    .i_is_div (func3_q[2]),
    .i_a      (abs_a),
    .i_b      (abs_b),
    .o_acc    (dp_acc)
  );

  // Operand conditioning: magnitudes, result sign and special-case flags for the incoming op.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (i_func3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    a_neg     = a_signed & i_rs1_data[XLEN-1];
    b_neg     = b_signed & i_rs2_data[XLEN-1];
    abs_a     = neg_if(a_neg, i_rs1_data);
    abs_b     = neg_if(b_neg, i_rs2_data);
    // Remainder takes the dividend's sign; products and quotients take the xor.
    res_neg   = (i_func3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
    in_b_zero = (i_rs2_data == '0);
    in_ovf    = ((i_func3 == F3_DIV) || (i_func3 == F3_REM)) &&
                (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
  end

`ifdef MULDIV_FAST_ZERO_EN
  // Zero-operand shortcut: products are zero; div-by-zero gives all-ones / dividend.
  always_comb begin
    fast_zero   = (i_rs1_data == '0) || in_b_zero;
    fast_result = '0;
    if (i_func3[2] && in_b_zero) begin
      fast_result = i_func3[1] ? i_rs1_data : '1;
    end
  end
`endif

  // Sign fixup and word selection from the finished accumulator.
  always_comb begin
    prod        = neg_q ? (~dp_acc + 1'b1) : dp_acc;
    quot        = dp_acc[XLEN-1:0];
    rem         = dp_acc[2*XLEN-1:XLEN];
    sign_result = '0;
    case (func3_q)
      F3_MUL:                       sign_result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: sign_result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (b_zero_q)   sign_result = '1;
        else if (ovf_q) sign_result = 32'h8000_0000;
        else            sign_result = neg_if(neg_q, quot);
      end
      default: begin
        if (b_zero_q)   sign_result = a_raw_q;
        else if (ovf_q) sign_result = '0;
        else            sign_result = neg_if(neg_q, rem);
      end
    endcase
  end

  // Next-state logic: flush wins over everything, otherwise walk IDLE->CALC->SIGN->DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func3_d  = func3_q;
    a_raw_d  = a_raw_q;
    neg_d    = neg_q;
    b_zero_d = b_zero_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            func3_d  = i_func3;
            a_raw_d  = i_rs1_data;
            neg_d    = res_neg;
            b_zero_d = in_b_zero;
            ovf_d    = in_ovf;
            cnt_d    = 5'd31;
            dp_load  = 1'b1;
            state_d  = ST_CALC;
`ifdef MULDIV_FAST_ZERO_EN
            if (fast_zero) begin
              cnt_d    = '0;
              result_d = fast_result;
              state_d  = ST_DONE;
            end
`endif
          end
        end
        ST_CALC: begin
          dp_step = 1'b1;
          if (cnt_q == 5'd0) begin
            state_d = ST_SIGN;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        ST_SIGN: begin
          result_d = sign_result;
          state_d  = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      func3_q  <= '0;
      a_raw_q  <= '0;
      neg_q    <= 1'b0;
      b_zero_q <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func3_q  <= func3_d;
      a_raw_q  <= a_raw_d;
      neg_q    <= neg_d;
      b_zero_q <= b_zero_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign o_stall  = ((state_q == ST_IDLE) && i_valid) || (state_q == ST_CALC) || (state_q == ST_SIGN);
  assign o_valid  = (state_q == ST_DONE) && !i_flush;
  assign o_busy   = (state_q != ST_IDLE);
  assign o_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: expected results are queued when an op
// is driven and popped when the result beat appears.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [2:0]  i_func3;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        i_flush;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  ex_muldiv_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_func3    (i_func3),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_flush    (i_flush),
    .o_stall    (o_stall),
    .o_valid    (o_valid),
    .o_result   (o_result),
    .o_busy     (o_busy)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Reference model built on the simulator's own arithmetic.
  function automatic logic [31:0] modelResult(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, ub;
    int          ia, ib;
    logic [63:0] ua, ubb;
    ia  = a;
    ib  = b;
    sa  = ia;
    sb  = ib;
    ub  = longint'({32'h0, b});
    ua  = {32'h0, a};
    ubb = {32'h0, b};
    modelResult = '0;
    case (f3)
      3'b000: begin p = ua * ubb; modelResult = p[31:0];  end
      3'b001: begin p = sa * sb;  modelResult = p[63:32]; end
      3'b010: begin p = sa * ub;  modelResult = p[63:32]; end
      3'b011: begin p = ua * ubb; modelResult = p[63:32]; end
      3'b100: begin
        if (b == 0) modelResult = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) modelResult = 32'h8000_0000;
        else modelResult = ia / ib;
      end
      3'b101: modelResult = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) modelResult = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) modelResult = 32'h0;
        else modelResult = ia % ib;
      end
      default: modelResult = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, want);
    end
  endtask

  // Drive one op, queue its expected result, then track stall length and result beat.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          cyc, stalls, valid_at, exp_stall;
    bit          got;
    logic [31:0] want;
    exp_q.push_back(modelResult(f3, a, b));
    exp_stall = 34;
`ifdef MULDIV_FAST_ZERO_EN
    if (a == 0 || b == 0) exp_stall = 1;
`endif
    @(negedge clk);
    i_func3    = f3;
    i_rs1_data = a;
    i_rs2_data = b;
    i_valid    = 1'b1;
    cyc = 0; stalls = 0; valid_at = 0; got = 0;
    while (!got && cyc < 100) begin
      #1;
      cyc++;
      if (o_stall) stalls++;
      if (o_valid) begin
        got      = 1;
        valid_at = cyc;
        want     = exp_q.pop_front();
        checkOutput($sformatf("result f3=%0d", f3), o_result, want);
      end else begin
        @(posedge clk);
        #1;
        i_valid    = 1'b0;
        i_func3    = 3'($urandom);
        i_rs1_data = $urandom;
        i_rs2_data = $urandom;
        @(negedge clk);
      end
    end
    if (!got) begin
      checkOutput("timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) want = exp_q.pop_front();
    end else begin
      checkOutput("stall_len", stalls, exp_stall);
      checkOutput("valid_cycle", valid_at, exp_stall + 1);
      @(negedge clk);
      #1;
      checkOutput("valid_pulse", {31'd0, o_valid}, 32'd0);
      checkOutput("busy_after", {31'd0, o_busy}, 32'd0);
    end
  endtask

  // Start a MUL, kill it in the 10th CALC cycle by flush or reset, then confirm it vanished.
  task automatic abortTest(input bit use_reset);
    int n;
    @(negedge clk);
    i_func3 = 3'b000; i_rs1_data = 32'd5; i_rs2_data = 32'd5; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    if (use_reset) rst_n = 1'b0;
    else           i_flush = 1'b1;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    i_flush = 1'b0;
    @(negedge clk);
    checkOutput(use_reset ? "rst_stall" : "flush_stall", {31'd0, o_stall}, 32'd0);
    checkOutput(use_reset ? "rst_busy" : "flush_busy", {31'd0, o_busy}, 32'd0);
    if (use_reset) checkOutput("rst_result", o_result, 32'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_valid) n++;
    end
    checkOutput(use_reset ? "rst_no_valid" : "flush_no_valid", n, 32'd0);
    applyStimulus(3'b000, 32'd3, 32'd3);
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_func3 = '0;
    i_rs1_data = '0; i_rs2_data = '0; i_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("reset_result", o_result, 32'd0);
    checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("reset_stall", {31'd0, o_stall}, 32'd0);
    i_valid = 1'b1; i_rs1_data = 32'd7; i_rs2_data = 32'd6;
    #1 checkOutput("reset_stall_ivalid", {31'd0, o_stall}, 32'd1);
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    checkOutput("reset_no_accept", {31'd0, o_busy}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(3'b000, 32'd7, 32'd6);
    applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'd2);
    applyStimulus(3'b100, 32'hFFFF_FFEC, 32'd3);
    applyStimulus(3'b110, 32'hFFFF_FFEC, 32'd3);
    applyStimulus(3'b101, 32'd100, 32'd7);
    applyStimulus(3'b111, 32'd100, 32'd7);
    applyStimulus(3'b100, 32'h1234_5678, 32'd0);
    applyStimulus(3'b110, 32'h1234_5678, 32'd0);
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(3'b101, 32'hFFFF_FFFF, 32'h8000_0001);
    applyStimulus(3'b111, 32'hFFFF_FFFF, 32'h8000_0001);
    applyStimulus(3'b000, 32'hFFFF_FFF9, 32'd6);
    applyStimulus(3'b001, 32'h8000_0000, 32'h7FFF_FFFF);
    for (int k = 0; k < 8; k++) applyStimulus(3'(k), $urandom, $urandom);

    abortTest(1'b0);
    abortTest(1'b1);

    applyStimulus(3'b100, 32'd5, 32'd0);
    applyStimulus(3'b000, 32'd0, 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
